// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel post-processing stage: pixel width,
// saturation limit, counter sizing and the per-beat payload layout.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  // One output beat: processed pixel plus end-of-line and start-of-frame flags.
  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             last;
    logic             user;
  } beat_t;

endpackage

// File: rtl/sobel_post_skid.sv
// Generic 2-entry ready/valid skid buffer. One output register plus one
// overflow slot; s_ready comes straight from a flop so downstream ready never
// reaches upstream combinationally.
module stream_skid2 #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         out_valid_reg, out_valid_next;
  logic [W-1:0] out_data_reg, out_data_next;
  logic         skid_valid_reg, skid_valid_next;
  logic [W-1:0] skid_data_reg, skid_data_next;
  logic         ready_reg, ready_next;
  logic         acc;
  logic         take;

  assign acc     = s_valid && ready_reg;
  assign take    = !out_valid_reg || m_ready;
  assign s_ready = ready_reg;
  assign m_valid = out_valid_reg;
  assign m_data  = out_data_reg;

  // Route each beat to the output slot when it can move, else park it in skid.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (take) begin
      if (skid_valid_reg) begin
        // Upstream is stalled while skid is full, so acc cannot occur here.
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        skid_valid_next = 1'b0;
      end else if (acc) begin
        out_valid_next = 1'b1;
        out_data_next  = s_data;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (acc) begin
      skid_valid_next = 1'b1;
      skid_data_next  = s_data;
    end
    ready_next = !skid_valid_next;
  end

  // State registers; reset empties both slots and opens the input.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      ready_reg      <= 1'b1;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      ready_reg      <= ready_next;
    end
  end

endmodule

// File: rtl/sobel_post.sv
// Sobel post-processing stage: saturates the gradient magnitude to 8 bits,
// blanks the leading border rows/columns, tags line/frame boundaries and
// buffers through a 2-entry skid. Optional macro EDGE_BINARIZE_EN turns the
// interior output into a 0x00/0xFF edge map against the runtime threshold.
module sobel_post
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int BORDER     = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_user,
  input  logic [7:0]            thresh,
  input  logic                  sof_clr,
  output logic                  frame_done
);

  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);

  logic [XW-1:0]    x_reg, x_next, x_eff;
  logic [YW-1:0]    y_reg, y_next, y_eff;
  logic             frame_done_reg, frame_done_next;
  logic             acc;
  logic [PIX_W-1:0] sat;
  logic [PIX_W-1:0] pix_val;
  logic             border;
  beat_t            beat_in;
  beat_t            beat_out;

  assign acc = s_valid && s_ready;

`ifndef EDGE_BINARIZE_EN
  // Threshold only matters for the binarized build.
  logic thresh_unused;
  assign thresh_unused = ^thresh;
`endif

  // Pixel path: a frame restart makes the current beat position (0,0).
  always_comb begin
    x_eff  = sof_clr ? '0 : x_reg;
    y_eff  = sof_clr ? '0 : y_reg;
    sat    = (s_data > DATA_WIDTH'(PIX_MAX)) ? PIX_MAX : s_data[PIX_W-1:0];
    border = (x_eff < XW'(BORDER)) || (y_eff < YW'(BORDER));
`ifdef EDGE_BINARIZE_EN
    pix_val = (sat >= thresh) ? PIX_MAX : '0;
`else
    pix_val = sat;
`endif
    beat_in.pix  = border ? '0 : pix_val;
    beat_in.last = (x_eff == XW'(IMG_WIDTH - 1));
    beat_in.user = (x_eff == '0) && (y_eff == '0);
  end

  // Raster counters advance per accepted beat; sof_clr alone just rewinds.
  always_comb begin
    x_next          = x_reg;
    y_next          = y_reg;
    frame_done_next = 1'b0;
    if (acc) begin
      if (x_eff == XW'(IMG_WIDTH - 1)) begin
        x_next = '0;
        if (y_eff == YW'(IMG_HEIGHT - 1)) begin
          y_next          = '0;
          frame_done_next = 1'b1;
        end else begin
          y_next = y_eff + YW'(1);
        end
      end else begin
        x_next = x_eff + XW'(1);
        y_next = y_eff;
      end
    end else if (sof_clr) begin
      x_next = '0;
      y_next = '0;
    end
  end

  // Position counters and the end-of-frame pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_reg          <= '0;
      y_reg          <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      x_reg          <= x_next;
      y_reg          <= y_next;
      frame_done_reg <= frame_done_next;
    end
  end

  stream_skid2 #(
    .W($bits(beat_t))
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (beat_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (beat_out)
  );

  assign m_data[PIX_W-1:0] = beat_out.pix;
  assign m_last            = beat_out.last;
  assign m_user            = beat_out.user;
  assign frame_done        = frame_done_reg;

  // Upper data bits carry nothing.
  genvar gi;
  generate
    for (gi = PIX_W; gi < DATA_WIDTH; gi++) begin : g_zero_hi
      assign m_data[gi] = 1'b0;
    end
  endgenerate

endmodule
